// File: rtl/mdu_iter.sv
// Iterative RV32 M-extension unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: 32 cycles from the accepting edge to result_valid; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: busy stalls the pipeline while iterating; start is ignored in BUSY; flush aborts with no result.
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [4:0]        cnt;
   logic [2:0]        f3;
   logic              sa;
   logic              sb;
   logic [XLEN-1:0]   opnd;   // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc;    // {product hi, multiplier} or {remainder, dividend/quotient}

   logic              accept;
   logic              is_div;
   logic              a_neg;
   logic              b_neg;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   special_res;

   // Decode the incoming request: operand signs, magnitudes and the two single-cycle special cases
   always_comb begin
      accept      = start && (state != S_BUSY) && !flush;
      is_div      = funct3[2];
      a_neg       = op_a[XLEN-1] & (is_div ? ~funct3[0] : (funct3[0] ^ funct3[1]));
      b_neg       = op_b[XLEN-1] & (is_div ? ~funct3[0] : (~funct3[1] & funct3[0]));
      mag_a       = a_neg ? -op_a : op_a;
      mag_b       = b_neg ? -op_b : op_b;
      div_zero    = is_div && (op_b == '0);
      div_ovf     = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      special_res = div_zero ? (funct3[1] ? op_a : '1)
                             : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
   end

   logic [XLEN:0]     upper;
   logic [XLEN:0]     mul_sum;
   logic              div_ge;
   logic [2*XLEN-1:0] acc_nx;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   final_res;

   // One radix-2 step of the datapath plus sign fix-up and final select of the completed value
   always_comb begin
      upper   = acc[2*XLEN-1:XLEN-1];
      div_ge  = upper >= {1'b0, opnd};
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      if (f3[2]) begin
         // remainder after a successful subtract is below the divisor, so 32 bits are exact
         acc_nx = div_ge ? {upper[XLEN-1:0] - opnd, acc[XLEN-2:0], 1'b1}
                         : {upper[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         acc_nx = {mul_sum, acc[XLEN-1:1]};
      end
      prod      = (sa ^ sb) ? -acc_nx : acc_nx;
      quo       = (sa ^ sb) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
      rem       = sa ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
      final_res = f3[2] ? (f3[1] ? rem : quo)
                        : ((f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end

   // Control FSM and datapath registers; flush outranks both start and completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         f3     <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         result <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else if (accept) begin
         f3  <= funct3;
         sa  <= a_neg;
         sb  <= b_neg;
         cnt <= '0;
         if (div_zero || div_ovf) begin
            state  <= S_DONE;
            result <= special_res;
            acc    <= '0;
            opnd   <= '0;
         end else begin
            state <= S_BUSY;
            acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd  <= is_div ? mag_b : mag_a;
         end
      end else if (state == S_BUSY) begin
         acc <= acc_nx;
         cnt <= cnt + 1'b1;
         if (cnt == 5'd31) begin
            state  <= S_DONE;
            result <= final_res;
         end
      end else if (state == S_DONE) begin
         state <= S_IDLE;
      end
   end

   // Status outputs decode straight from the state so reset clears them immediately
   always_comb begin
      busy         = (state == S_BUSY);
      result_valid = (state == S_DONE);
   end
endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;

   mdu_iter #(.XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .funct3       (funct3),
      .op_a         (op_a),
      .op_b         (op_b),
      .flush        (flush),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic following the RISC-V M rules
   function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      p  = 64'd0;
      case (f)
         3'd0: begin p = ua * ub;             r = p[31:0];  end
         3'd1: begin p = sa * sb;             r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub);   r = p[63:32]; end
         3'd3: begin p = ua * ub;             r = p[63:32]; end
         default: begin
            if (b == 32'd0) begin
               r = f[1] ? a : 32'hFFFFFFFF;
            end else begin
               if (f[0]) begin
                  if (f[1]) p = ua % ub;
                  else      p = ua / ub;
               end else begin
                  if (f[1]) p = sa % sb;
                  else      p = sa / sb;
               end
               r = p[31:0];
            end
         end
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = 32'hFFFFFFFF;
         3: v = 32'h80000000;
         default: v = $urandom();
      endcase
      return v;
   endfunction

   // Call at a negedge. Returns at the negedge where result_valid is seen (or the bound expires).
   // exp_lat counts clock edges after the accepting edge until result_valid is visible.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat = 0;
      int bcnt = 0;
      rst_n  = 1'b1;
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      @(negedge clk);
      start  = 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      op_a   = $urandom();
      op_b   = $urandom();
      while (!result_valid && lat < 100) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_res"}, result, exp_res);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busy"}, bcnt, exp_lat);
   endtask

   task automatic watch_quiet(input string tag, input int n);
      int pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (result_valid) pulses++;
      end
      check(tag, pulses, 0);
   endtask

   initial begin
      logic [2:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;
      int          rl;

      // reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_result", result, 0);
      repeat (2) @(negedge clk);

      // start on the very first edge after reset release
      run_op("mul_7x-3", 3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32);
      @(negedge clk);
      check("done_one_cycle", result_valid, 0);
      check("result_hold", result, 32'hFFFFFFEB);

      // directed multiply/divide cases; each start lands in DONE of the previous one
      run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32);
      run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
      run_op("div_-7_2", 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32);
      run_op("rem_-7_2", 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32);
      run_op("divu_5_0", 3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0);
      run_op("remu_5_0", 3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 0);
      run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
      run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);

      // flush in busy cycle 10 together with a start that must be discarded
      start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("flush_pre_busy", busy, 1);
      flush = 1'b1; start = 1'b1;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_valid", result_valid, 0);
      check("flush_result_hold", result, 32'h80000000);
      watch_quiet("flush_quiet", 40);

      // asynchronous reset in busy cycle 20
      start = 1'b1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("rst_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", result_valid, 0);
      check("rst_mid_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_quiet("rst_quiet", 40);

      // randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         rl = (rf[2] && (rb == 32'd0 || (!rf[0] && ra == 32'h80000000 && rb == 32'hFFFFFFFF))) ? 0 : 32;
         run_op("rand", rf, ra, rb, ref_mdu(rf, ra, rb), rl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
